mem_store_responder: RTL and testbench
======================================

Name: mem_store_responder

Overview:
- Memory-side responder for the ME stage's request interface.
- Accepts the 65-bit edit serial {is_edit, word_addr[31:0], data[31:0]} and a word fetch address.
- Returns read data and buffers writes in a small in-order store buffer that drains into a word-addressed data array.
- Sits between the ME stage and data storage. Provides store-to-load forwarding and back-pressures the pipeline when the buffer is full.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data array (power of two).
- SB_DEPTH, 4, store buffer entries (power of two, >=2).

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- Enable  input  1  block enable. When 0: no accept, no drain, ReadData=0.
- FetchAddress  input  32  word address of the load.
- EditSerial  input  65  bit64=is_edit, bits63:32=word address, bits31:0=write data.
- ReadData  output  32  load result, combinational.
- Stall  output  1  combinational. Equals Enable & is_edit & SbFull. Requester holds EditSerial while Stall=1.
- SbFull  output  1  buffer count == SB_DEPTH.
- SbCount  output  $clog2(SB_DEPTH)+1  valid store buffer entries.
- OutOfRange  output  1  sticky error flag.

Behaviour:
- Clock and reset:
  - One clock, Clock.
  - Reset is synchronous, active-low (Reset_n).
  - Reset sampled at a rising edge clears SbCount=0, head/tail pointers=0, all entry valid bits, and OutOfRange=0.
  - Array contents are not reset.
  - Reset mid-operation discards buffered stores; they never reach the array.
- Accept (store):
  - At a rising edge, an edit is accepted iff Enable=1, is_edit=1 and SbFull=0.
  - The accepted {addr, data} is written at the tail, the tail increments (mod SB_DEPTH), and the count increments.
  - Each cycle with is_edit=1 and no stall is a distinct store.
- Drain:
  - At a rising edge with Enable=1, count>0 and no edit accepted that cycle, the head entry is written to the array, the head increments, and the count decrements.
  - The array has a single write port, so accept has priority over drain.
  - With count=SB_DEPTH and is_edit=1: Stall=1, no accept, a drain occurs, and the next cycle accepts.
- Load (combinational):
  - If FetchAddress >= DEPTH_WORDS, ReadData=0.
  - Otherwise ReadData = data of the youngest valid buffer entry whose addr equals FetchAddress.
  - If no entry matches, ReadData = array[FetchAddress].
  - An edit presented in the same cycle is not forwarded; loads see the state before the edge.
- Out of range:
  - A store with addr >= DEPTH_WORDS is accepted into the buffer like any other.
  - On drain it is discarded (no array write) and OutOfRange sets.
  - A load with FetchAddress >= DEPTH_WORDS while Enable=1 also sets OutOfRange at the next edge.
  - OutOfRange clears only on reset.
- Ordering: drains are strictly FIFO. Multiple entries with the same address drain oldest-first, so the array holds the youngest value at the end.
- Width rules: only addr[$clog2(DEPTH_WORDS)-1:0] indexes the array, after the range check against the full 32-bit address.
- Enable=0: state holds, Stall=0, ReadData=0.

Decomposition:
- Shared package mem_pkg:
  - Edit serial field positions: IS_EDIT_BIT=64, ADDR_MSB=63, ADDR_LSB=32, DATA_MSB=31.
  - Store entry typedef {valid, addr[31:0], data[31:0]}.
- One natural sub-module: store_buffer. It holds the circular queue, pointers, count, full flag, and the youngest-match forwarding search.
- The top level holds the array, range checks, drain write and read mux.

Test Plan:
1. Reset, then store {1, addr 5, 0xDEADBEEF} for one cycle, then idle. Required: SbCount=1 after edge 1, 0 after edge 2, array[5]=0xDEADBEEF.
2. Store addr 7 = 0x11, then next cycle present FetchAddress=7 with is_edit=0. Required: ReadData=0x11 forwarded while the entry is buffered, and still 0x11 after drain.
3. Store addr 3 = 0xA then 0xB back-to-back, then load addr 3 before drain. Required: ReadData=0xB. After both drain, array[3]=0xB.
4. Five consecutive stores to addr 0..4 with SB_DEPTH=4. Required:
   - SbFull=1 after the 4th.
   - Stall=1 during the 5th cycle, with one drain that cycle.
   - The 5th store is accepted the following cycle.
   - Final array[0..4] holds correct data.
5. Store to addr 300, then load FetchAddress=300. Required: ReadData=0, OutOfRange=1, and no array word altered.
6. Fill the buffer with 3 stores, assert Reset_n=0 for one edge. Required: SbCount=0, OutOfRange=0, and the target array words remain unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side store responder: edit serial layout,
// store buffer entry format and the address range check.
package mem_pkg;

  localparam int IS_EDIT_BIT = 64;
  localparam int ADDR_MSB    = 63;
  localparam int ADDR_LSB    = 32;
  localparam int DATA_MSB    = 31;
  localparam int EDIT_W      = 65;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  // The full 32-bit address is checked before any truncation to an array index.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_store_responder_if.sv
// Request/response bundle between the ME stage (master) and the memory-side
// store responder (slave).
interface mem_store_responder_if #(
  parameter int SB_DEPTH = 4
);
  import mem_pkg::*;

  logic                      Enable;
  logic [31:0]               FetchAddress;
  logic [EDIT_W-1:0]         EditSerial;
  logic [31:0]               ReadData;
  logic                      Stall;
  logic                      SbFull;
  logic [$clog2(SB_DEPTH):0] SbCount;
  logic                      OutOfRange;

  modport master (
    output Enable, FetchAddress, EditSerial,
    input  ReadData, Stall, SbFull, SbCount, OutOfRange
  );

  modport slave (
    input  Enable, FetchAddress, EditSerial,
    output ReadData, Stall, SbFull, SbCount, OutOfRange
  );

endinterface

// File: rtl/mem_store_responder_store_buffer.sv
// In-order circular store buffer with youngest-match forwarding lookup.
// Only the control state (pointers, count, valid bits) is reset.
module mem_store_responder_store_buffer
  import mem_pkg::*;
#(
  parameter  int SB_DEPTH = 4,
  localparam int PTR_W    = $clog2(SB_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [31:0]      push_addr,
  input  logic [31:0]      push_data,
  input  logic             pop,
  input  logic [31:0]      look_addr,
  output logic             hit,
  output logic [31:0]      hit_data,
  output logic [31:0]      head_addr,
  output logic [31:0]      head_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  sb_entry_t        entries [SB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i].valid <= 1'b0;
    end else if (push) begin
      entries[tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
      tail          <= tail + PTR_W'(1);
      count         <= count + CNT_W'(1);
    end else if (pop) begin
      entries[head].valid <= 1'b0;
      head                <= head + PTR_W'(1);
      count               <= count - CNT_W'(1);
    end
  end

  assign full      = (count == CNT_W'(SB_DEPTH));
  assign head_addr = entries[head].addr;
  assign head_data = entries[head].data;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entries[idx].valid && (entries[idx].addr == look_addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_store_responder.sv
// Memory-side responder: word array fed by an in-order store buffer, with
// store-to-load forwarding, back-pressure and a sticky out-of-range flag.
module mem_store_responder
  import mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int SB_DEPTH    = 4,
  localparam int AW          = $clog2(DEPTH_WORDS),
  localparam int CNT_W       = $clog2(SB_DEPTH) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  mem_store_responder_if.slave  bus
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic             is_edit;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             accept;
  logic             drain;
  logic             fetch_ok;
  logic             head_ok;
  logic             sb_hit;
  logic [31:0]      sb_hit_data;
  logic [31:0]      head_addr;
  logic [31:0]      head_data;
  logic [CNT_W-1:0] sb_count;
  logic             sb_full;
  logic             oor;

  assign is_edit = bus.EditSerial[IS_EDIT_BIT];
  assign st_addr = bus.EditSerial[ADDR_MSB:ADDR_LSB];
  assign st_data = bus.EditSerial[DATA_MSB:0];

  // Single array write port: accept wins, and a reset edge never drains.
  assign accept   = bus.Enable && is_edit && !sb_full;
  assign drain    = Reset_n && bus.Enable && (sb_count != '0) && !accept;
  assign fetch_ok = addr_in_range(bus.FetchAddress, DEPTH_WORDS);
  assign head_ok  = addr_in_range(head_addr, DEPTH_WORDS);

  mem_store_responder_store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (accept),
    .push_addr (st_addr),
    .push_data (st_data),
    .pop       (drain),
    .look_addr (bus.FetchAddress),
    .hit       (sb_hit),
    .hit_data  (sb_hit_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (sb_count),
    .full      (sb_full)
  );

  always_ff @(posedge Clock) begin
    if (drain && head_ok) mem[head_addr[AW-1:0]] <= head_data;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) oor <= 1'b0;
    else if ((drain && !head_ok) || (bus.Enable && !fetch_ok)) oor <= 1'b1;
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.Enable && fetch_ok)
      bus.ReadData = sb_hit ? sb_hit_data : mem[bus.FetchAddress[AW-1:0]];
  end

  assign bus.Stall      = bus.Enable && is_edit && sb_full;
  assign bus.SbFull     = sb_full;
  assign bus.SbCount    = sb_count;
  assign bus.OutOfRange = oor;

endmodule

// File: tb/tb_mem_store_responder.sv
// Randomized and directed bench for mem_store_responder against a queue-based
// model of the store buffer and word array.
module tb_mem_store_responder;

  localparam int DEPTH = 256;
  localparam int SBD   = 4;

  logic Clock;
  logic Reset_n;

  mem_store_responder_if #(.SB_DEPTH(SBD)) bus ();

  mem_store_responder #(.DEPTH_WORDS(DEPTH), .SB_DEPTH(SBD)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // Model: pending stores oldest-first, array image, sticky error flag.
  logic [63:0] q [$];
  logic [31:0] mm [DEPTH];
  bit          known [DEPTH];
  bit          m_oor;
  bit          m_stall;

  function automatic logic [31:0] ival(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    logic [63:0] e;
    m_stall = Reset_n && bus.Enable && bus.EditSerial[64] && (q.size() == SBD);
    if (!Reset_n) begin
      q.delete();
      m_oor = 0;
    end else if (bus.Enable) begin
      if (bus.EditSerial[64] && q.size() < SBD) begin
        q.push_back(bus.EditSerial[63:0]);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e[63:32] < DEPTH) begin
          mm[e[39:32]]    = e[31:0];
          known[e[39:32]] = 1;
        end else begin
          m_oor = 1;
        end
      end
      if (bus.FetchAddress >= DEPTH) m_oor = 1;
    end
  end

  always @(negedge Clock) begin
    logic [31:0] e;
    bit          ev;
    if (chk_on) begin
      e  = '0;
      ev = 1;
      if (bus.Enable && bus.FetchAddress < DEPTH) begin
        ev = 0;
        for (int i = 0; i < q.size(); i++)
          if (q[i][63:32] == bus.FetchAddress) begin
            e  = q[i][31:0];
            ev = 1;
          end
        if (!ev && known[bus.FetchAddress[7:0]]) begin
          e  = mm[bus.FetchAddress[7:0]];
          ev = 1;
        end
      end
      if (ev) chk("rdata", bus.ReadData, e);
      chk("stall", 32'(bus.Stall), 32'(bus.Enable && bus.EditSerial[64] && q.size() == SBD));
      chk("full", 32'(bus.SbFull), 32'(q.size() == SBD));
      chk("count", 32'(bus.SbCount), 32'(q.size()));
      chk("oor", 32'(bus.OutOfRange), 32'(m_oor));
    end
  end

  task automatic drive(input logic en, input logic rn, input logic [31:0] fa, input logic [64:0] es);
    bus.Enable       = en;
    Reset_n          = rn;
    bus.FetchAddress = fa;
    bus.EditSerial   = es;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int n;
    drive(1'b1, 1'b1, 32'd0, {1'b1, a, d});
    #1;
    n = 0;
    while (bus.Stall && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("stall_bound", 32'(n), 32'd0);
    tick();
  endtask

  task automatic idle(input logic [31:0] fa, input int n);
    drive(1'b1, 1'b1, fa, 65'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] es;
    logic        en;
    logic        rn;
    logic [31:0] fa;
    logic [31:0] a;

    drive(1'b0, 1'b0, 32'd0, 65'd0);
    tick();
    tick();
    chk_on = 1;
    chk("reset_count", 32'(bus.SbCount), 32'd0);
    chk("reset_oor", 32'(bus.OutOfRange), 32'd0);
    chk("reset_full", 32'(bus.SbFull), 32'd0);

    for (int i = 0; i < DEPTH; i++) store(32'(i), ival(i));
    idle(32'd0, 8);

    // 1: single store drains on the next idle edge
    drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd5, 32'hDEAD_BEEF});
    tick();
    chk("t1_count1", 32'(bus.SbCount), 32'd1);
    drive(1'b1, 1'b1, 32'd5, 65'd0);
    tick();
    chk("t1_count0", 32'(bus.SbCount), 32'd0);
    chk("t1_array5", bus.ReadData, 32'hDEAD_BEEF);

    // 2: forwarding while buffered, then from the array
    drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd7, 32'h11});
    tick();
    drive(1'b1, 1'b1, 32'd7, 65'd0);
    #1;
    chk("t2_fwd", bus.ReadData, 32'h11);
    tick();
    chk("t2_drained", bus.ReadData, 32'h11);

    // 3: youngest of two same-address stores wins
    drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd3, 32'hA});
    tick();
    drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd3, 32'hB});
    tick();
    drive(1'b1, 1'b1, 32'd3, 65'd0);
    #1;
    chk("t3_fwd_young", bus.ReadData, 32'hB);
    tick();
    tick();
    chk("t3_count", 32'(bus.SbCount), 32'd0);
    chk("t3_array", bus.ReadData, 32'hB);

    // 4: fill, stall with a drain, then accept
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'd0, {1'b1, 32'(i), 32'h4000 + 32'(i)});
      tick();
    end
    chk("t4_full", 32'(bus.SbFull), 32'd1);
    drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd4, 32'h4004});
    #1;
    chk("t4_stall", 32'(bus.Stall), 32'd1);
    tick();
    chk("t4_drain_count", 32'(bus.SbCount), 32'd3);
    chk("t4_stall_gone", 32'(bus.Stall), 32'd0);
    tick();
    chk("t4_accept_count", 32'(bus.SbCount), 32'd4);
    idle(32'd0, 6);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'(i), 65'd0);
      #1;
      chk("t4_array", bus.ReadData, 32'h4000 + 32'(i));
    end

    // 5: out-of-range store and load
    drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd300, 32'h5555_5555});
    tick();
    drive(1'b1, 1'b1, 32'd300, 65'd0);
    #1;
    chk("t5_rdata", bus.ReadData, 32'd0);
    tick();
    chk("t5_oor", 32'(bus.OutOfRange), 32'd1);
    drive(1'b1, 1'b1, 32'd44, 65'd0);
    #1;
    chk("t5_alias44", bus.ReadData, ival(44));
    idle(32'd0, 3);

    // 6: reset discards buffered stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'd0, {1'b1, 32'd10 + 32'(i), 32'h6000 + 32'(i)});
      tick();
    end
    chk("t6_count3", 32'(bus.SbCount), 32'd3);
    drive(1'b1, 1'b0, 32'd0, 65'd0);
    tick();
    chk("t6_count0", 32'(bus.SbCount), 32'd0);
    chk("t6_oor0", 32'(bus.OutOfRange), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'd10 + 32'(i), 65'd0);
      #1;
      chk("t6_array", bus.ReadData, ival(10 + i));
    end

    // Random traffic, narrow address range so forwarding hits are common
    es = 65'd0;
    en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if (!m_stall) begin
        en = ($urandom_range(0, 7) != 0);
        a  = ($urandom_range(0, 31) == 0) ? 32'($urandom_range(256, 1000))
           : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255))
           : 32'($urandom_range(0, 11));
        es = {1'($urandom_range(0, 1)), a, 32'($urandom)};
      end
      rn = ($urandom_range(0, 299) != 0) || m_stall;
      fa = ($urandom_range(0, 39) == 0) ? 32'($urandom_range(256, 70000))
         : 32'($urandom_range(0, 15));
      drive(en, rn, fa, es);
      tick();
    end
    idle(32'd0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
